// File: rtl/svo_tmds_pkg.sv
// rtl/svo_tmds_pkg.sv - shared constants and symbol tables for the TMDS/TERC4 encoder
//
// Purpose: symbol mode encodings, CTRL and TERC4 code tables, guard-band words
//          and the popcount helper used by the TMDS video path.
// Contents:
//   mode_e       - symbol mode (CTRL/VIDEO/VGUARD/DATA/DGUARD)
//   mode_norm()  - folds the unused codes 5..7 onto CTRL
//   ctrl_word()  - 2-bit control to 10-bit control symbol
//   terc4()      - 4-bit nibble to 10-bit TERC4 symbol
//   n1()         - number of ones in a byte
package svo_tmds_pkg;

  typedef enum logic [2:0] {
    M_CTRL   = 3'd0,
    M_VIDEO  = 3'd1,
    M_VGUARD = 3'd2,
    M_DATA   = 3'd3,
    M_DGUARD = 3'd4
  } mode_e;

  localparam logic [9:0] VGUARD_EVEN = 10'b1011001100;
  localparam logic [9:0] VGUARD_ODD  = 10'b0100110011;
  localparam logic [9:0] DGUARD_WORD = 10'b0100110011;

  function automatic mode_e mode_norm(input logic [2:0] m);
    if (m > 3'd4) return M_CTRL;
    return mode_e'(m);
  endfunction

  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] a);
    case (a)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] n1(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/svo_tmds_enc_if.sv
// rtl/svo_tmds_enc_if.sv - symbol input / encoded output bundle for svo_tmds_enc
//
// Purpose: groups the per-cycle symbol request and the encoded result.
// Signals:
//   mode    - symbol mode, common to all channels
//   ctrl    - {c1,c0} per channel, channel k at [2k+1:2k]
//   din     - video byte per channel, channel k at [8k+7:8k]
//   aux     - TERC4 nibble per channel, channel k at [4k+3:4k]
//   dout    - 10-bit symbol per channel, channel k at [10k+9:10k], bit 0 sent first
//   seq_err - guard-band sequencing violation pulse, aligned with dout
interface svo_tmds_enc_if #(parameter int NCH = 3);
  logic [2:0]        mode;
  logic [2*NCH-1:0]  ctrl;
  logic [8*NCH-1:0]  din;
  logic [4*NCH-1:0]  aux;
  logic [10*NCH-1:0] dout;
  logic              seq_err;

  modport master (output mode, ctrl, din, aux, input dout, seq_err);
  modport slave  (input mode, ctrl, din, aux, output dout, seq_err);
endinterface

// File: rtl/svo_tmds_ch.sv
// rtl/svo_tmds_ch.sv - one TMDS/TERC4 channel: mode mux, 8b/10b core, disparity counter
//
// Purpose: encodes one symbol per cycle and registers it together with the
//          running DC-balance count of this channel.
// Ports:
//   clk, resetn - pixel clock, async active-low reset
//   mode        - normalised symbol mode
//   ctrl        - this channel's {c1,c0}
//   din         - this channel's video byte
//   aux         - this channel's TERC4 nibble
//   sym         - registered 10-bit symbol
module svo_tmds_ch
  import svo_tmds_pkg::*;
#(
  parameter int CH_INDEX = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  mode_e      mode,
  input  logic [1:0] ctrl,
  input  logic [7:0] din,
  input  logic [3:0] aux,
  output logic [9:0] sym
);

  logic signed [7:0] cnt;
  logic signed [7:0] vid_cnt;
  logic signed [7:0] diff;
  logic [8:0]        q_m;
  logic [3:0]        n1d;
  logic [3:0]        n1q;
  logic              use_xnor;
  logic              acc;
  logic [9:0]        vid_word;
  logic [9:0]        word;

  always_comb begin
    n1d      = n1(din);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
    acc      = din[0];
    q_m      = '0;
    q_m[0]   = acc;
    for (int i = 1; i < 8; i++) begin
      acc    = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
      q_m[i] = acc;
    end
    q_m[8] = ~use_xnor;
    n1q    = n1(q_m[7:0]);
    // N1 - N0 of the 8 data bits, i.e. 2*N1 - 8
    diff   = $signed({3'b000, n1q, 1'b0}) - 8'sd8;

    if (cnt == 8'sd0 || n1q == 4'd4) begin
      vid_word = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      vid_cnt  = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[7] && diff > 8'sd0) || (cnt[7] && diff < 8'sd0)) begin
      // running disparity and word disparity have the same sign: invert
      vid_word = {1'b1, q_m[8], ~q_m[7:0]};
      vid_cnt  = cnt - diff + (q_m[8] ? 8'sd2 : 8'sd0);
    end else begin
      vid_word = {1'b0, q_m[8], q_m[7:0]};
      vid_cnt  = cnt + diff - (q_m[8] ? 8'sd0 : 8'sd2);
    end
  end

  always_comb begin
    word = ctrl_word(ctrl);
    case (mode)
      M_VIDEO:  word = vid_word;
      M_VGUARD: word = ((CH_INDEX % 2) == 0) ? VGUARD_EVEN : VGUARD_ODD;
      M_DATA:   word = terc4(aux);
      // channel 0 carries vsync/hsync inside its data guard band
      M_DGUARD: word = (CH_INDEX == 0) ? terc4({2'b11, ctrl}) : DGUARD_WORD;
      default:  word = ctrl_word(ctrl);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sym <= '0;
      cnt <= '0;
    end else begin
      sym <= word;
      cnt <= (mode == M_VIDEO) ? vid_cnt : 8'sd0;
    end
  end

endmodule

// File: rtl/svo_tmds_enc.sv
// rtl/svo_tmds_enc.sv - multi-channel TMDS/TERC4 encoder with guard checker and retiming
//
// Purpose: NCH encoder channels sharing one mode, a guard-band sequencing
//          checker, and an OUT_STAGES-deep output delay line.
// Ports:
//   clk, resetn - pixel clock, async active-low reset
//   bus         - svo_tmds_enc_if slave: mode/ctrl/din/aux in, dout/seq_err out
// Latency: 1 + OUT_STAGES cycles for both dout and seq_err.
module svo_tmds_enc
  import svo_tmds_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int OUT_STAGES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  svo_tmds_enc_if.slave  bus
);

  localparam int W = 10 * NCH + 1;

  mode_e             cur_mode;
  mode_e             prev_mode;
  logic [1:0]        run;
  logic              is_guard;
  logic              err_d;
  logic              err_q;
  logic [10*NCH-1:0] sym_all;
  logic [W-1:0]      enc_word;
  logic [W-1:0]      tap [OUT_STAGES+1];

  assign cur_mode = mode_norm(bus.mode);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    svo_tmds_ch #(.CH_INDEX(k)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .mode   (cur_mode),
      .ctrl   (bus.ctrl[2*k +: 2]),
      .din    (bus.din[8*k +: 8]),
      .aux    (bus.aux[4*k +: 4]),
      .sym    (sym_all[10*k +: 10])
    );
  end

  // Guard checker: prev_mode plus the length of the current guard run.
  assign is_guard = (cur_mode == M_VGUARD) || (cur_mode == M_DGUARD);

  always_comb begin
    err_d = 1'b0;
    if (cur_mode == M_VIDEO && prev_mode != M_VIDEO && prev_mode != M_VGUARD)
      err_d = 1'b1;
    if (cur_mode == M_DATA && prev_mode != M_DATA && prev_mode != M_DGUARD)
      err_d = 1'b1;
    // a guard run ends whenever the mode leaves it; only length 2 is legal
    if ((prev_mode == M_VGUARD || prev_mode == M_DGUARD) &&
        cur_mode != prev_mode && run != 2'd2)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_mode <= M_CTRL;
      run       <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      prev_mode <= cur_mode;
      err_q     <= err_d;
      if (!is_guard)
        run <= 2'd0;
      else if (cur_mode != prev_mode)
        run <= 2'd1;
      else if (run != 2'd3)
        run <= run + 2'd1;
    end
  end

  assign enc_word = {err_q, sym_all};
  assign tap[0]   = enc_word;

  for (genvar s = 0; s < OUT_STAGES; s++) begin : g_stage
    logic [W-1:0] q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) q <= '0;
      else         q <= tap[s];
    end
    assign tap[s+1] = q;
  end

  assign bus.dout    = tap[OUT_STAGES][10*NCH-1:0];
  assign bus.seq_err = tap[OUT_STAGES][W-1];

endmodule

// File: tb/tb_svo_tmds_enc.sv
// tb/tb_svo_tmds_enc.sv - bench for svo_tmds_enc at OUT_STAGES 0, 2 and 4
module tb_svo_tmds_enc;

  localparam int NCH = 3;
  localparam int W   = 10 * NCH + 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [2:0]       mode;
  logic [2*NCH-1:0] ctrl;
  logic [8*NCH-1:0] din;
  logic [4*NCH-1:0] aux;

  svo_tmds_enc_if #(.NCH(NCH)) if0 ();
  svo_tmds_enc_if #(.NCH(NCH)) if2 ();
  svo_tmds_enc_if #(.NCH(NCH)) if4 ();

  assign if0.mode = mode; assign if0.ctrl = ctrl; assign if0.din = din; assign if0.aux = aux;
  assign if2.mode = mode; assign if2.ctrl = ctrl; assign if2.din = din; assign if2.aux = aux;
  assign if4.mode = mode; assign if4.ctrl = ctrl; assign if4.din = din; assign if4.aux = aux;

  svo_tmds_enc #(.NCH(NCH), .OUT_STAGES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  svo_tmds_enc #(.NCH(NCH), .OUT_STAGES(2)) dut2 (.clk(clk), .resetn(resetn), .bus(if2));
  svo_tmds_enc #(.NCH(NCH), .OUT_STAGES(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4));

  logic [9:0] terc4_t [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  logic [9:0] ctrl_t [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;
  logic [W-1:0] hist [8];
  int cnt_m [NCH];
  int prev_m;
  int run_m;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // Reference TMDS video encoding from the count-of-ones rules.
  function automatic logic [9:0] tmds_video(input logic [7:0] d, input int k);
    int ones, n1q, n0q;
    logic [7:0] q;
    logic q8;
    logic [9:0] s;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    q8 = !((ones > 4) || (ones == 4 && d[0] == 1'b0));
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
    n1q = 0;
    for (int b = 0; b < 8; b++) n1q += int'(q[b]);
    n0q = 8 - n1q;
    if (cnt_m[k] == 0 || n1q == n0q) begin
      s = {~q8, q8, q8 ? q : ~q};
      cnt_m[k] += q8 ? (n1q - n0q) : (n0q - n1q);
    end else if ((cnt_m[k] > 0 && n1q > n0q) || (cnt_m[k] < 0 && n0q > n1q)) begin
      s = {1'b1, q8, ~q};
      cnt_m[k] += (n0q - n1q) + 2 * int'(q8);
    end else begin
      s = {1'b0, q8, q};
      cnt_m[k] += (n1q - n0q) - 2 * (1 - int'(q8));
    end
    return s;
  endfunction

  task automatic model(output logic [W-1:0] w);
    int m;
    logic err;
    m = (mode > 3'd4) ? 0 : int'(mode);
    err = 1'b0;
    if (m == 1 && prev_m != 1 && prev_m != 2) err = 1'b1;
    if (m == 3 && prev_m != 3 && prev_m != 4) err = 1'b1;
    if ((prev_m == 2 || prev_m == 4) && m != prev_m && run_m != 2) err = 1'b1;
    run_m = (m == 2 || m == 4) ? ((m == prev_m) ? run_m + 1 : 1) : 0;
    prev_m = m;
    w = '0;
    for (int k = 0; k < NCH; k++) begin
      logic [9:0] s;
      case (m)
        1:       s = tmds_video(din[8*k +: 8], k);
        2:       s = (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
        3:       s = terc4_t[aux[4*k +: 4]];
        4:       s = (k == 0) ? terc4_t[{2'b11, ctrl[1:0]}] : 10'b0100110011;
        default: s = ctrl_t[ctrl[2*k +: 2]];
      endcase
      if (m != 1) cnt_m[k] = 0;
      w[10*k +: 10] = s;
    end
    w[W-1] = err;
  endtask

  function automatic logic [W-1:0] expect_at(input int lat);
    if (cyc - lat >= base) return hist[(cyc - lat) % 8];
    return '0;
  endfunction

  task automatic step();
    logic [W-1:0] w;
    model(w);
    hist[cyc % 8] = w;
    @(posedge clk);
    #1;
    chk("os0", {if0.seq_err, if0.dout}, expect_at(0));
    chk("os2", {if2.seq_err, if2.dout}, expect_at(2));
    chk("os4", {if4.seq_err, if4.dout}, expect_at(4));
    cyc++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
    prev_m = 0;
    run_m = 0;
    base = cyc;
  endtask

  initial begin
    logic [31:0] r;
    resetn = 1'b0;
    mode = 3'd0; ctrl = '0; din = '0; aux = '0;
    model_reset();
    #12;
    chk("rst_os0", {if0.seq_err, if0.dout}, '0);
    chk("rst_os2", {if2.seq_err, if2.dout}, '0);
    chk("rst_os4", {if4.seq_err, if4.dout}, '0);
    @(negedge clk);
    resetn = 1'b1;

    // video din=0 twice: disparity walks 0 -> -8 -> +2
    mode = 3'd1; din = '0;
    step(); chk("vid0_a", {21'd0, if0.dout[9:0]}, {21'd0, 10'b0100000000});
    step(); chk("vid0_b", {21'd0, if0.dout[9:0]}, {21'd0, 10'b1111111111});
    chk("lat3_pre", {21'd0, if2.dout[9:0]}, '0);
    mode = 3'd0; ctrl = 6'b00_00_11;
    step();
    chk("ctrl_ch0", {21'd0, if0.dout[9:0]}, {21'd0, 10'b1010101011});
    chk("ctrl_ch1", {21'd0, if0.dout[19:10]}, {21'd0, 10'b1101010100});
    chk("lat3", {21'd0, if2.dout[9:0]}, {21'd0, 10'b0100000000});
    mode = 3'd2;
    step();
    chk("vg_ch0", {21'd0, if0.dout[9:0]}, {21'd0, 10'b1011001100});
    chk("vg_ch1", {21'd0, if0.dout[19:10]}, {21'd0, 10'b0100110011});
    chk("vg_ch2", {21'd0, if0.dout[29:20]}, {21'd0, 10'b1011001100});
    mode = 3'd3; aux = 12'h0F5;
    step();
    chk("data_ch0", {21'd0, if0.dout[9:0]}, {21'd0, 10'b0100011110});
    chk("data_ch1", {21'd0, if0.dout[19:10]}, {21'd0, 10'b1011000011});
    mode = 3'd4; ctrl = 6'b00_00_10;
    step();
    chk("dg_ch0", {21'd0, if0.dout[9:0]}, {21'd0, 10'b0101100011});

    // guard sequencing
    mode = 3'd0; step();
    mode = 3'd2; step(); step();
    mode = 3'd1; step();
    chk("seq_ok", {30'd0, if0.seq_err}, '0);
    mode = 3'd0; step();
    mode = 3'd2; step();
    mode = 3'd1; step();
    chk("seq_vg1", {30'd0, if0.seq_err}, {30'd0, 1'b1});
    step();
    chk("seq_vg1_once", {30'd0, if0.seq_err}, '0);
    mode = 3'd0; step();
    mode = 3'd3; step();
    chk("seq_data", {30'd0, if0.seq_err}, {30'd0, 1'b1});

    // disparity cleared by a single CTRL cycle
    mode = 3'd1; din = '0; step(); step(); step();
    mode = 3'd0; step();
    mode = 3'd1; din = '0; step();
    chk("disp_rst", {21'd0, if0.dout[9:0]}, {21'd0, 10'b0100000000});

    // asynchronous reset in the middle of a video run
    for (int i = 0; i < 5; i++) begin
      r = $urandom; din = r[8*NCH-1:0];
      step();
    end
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_os0", {if0.seq_err, if0.dout}, '0);
    chk("mid_rst_os2", {if2.seq_err, if2.dout}, '0);
    chk("mid_rst_os4", {if4.seq_err, if4.dout}, '0);
    @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();

    // random run: sticky modes give video lines and guard runs of mixed length
    mode = 3'd1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 9) < 2) mode = 3'($urandom_range(0, 7));
      r = $urandom; din = r[8*NCH-1:0];
      r = $urandom; ctrl = r[2*NCH-1:0]; aux = r[31 -: 4*NCH];
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
